// File: rtl/cpu_mc.sv
// Multicycle RV32I core: FETCH/DECODE/EXEC/MEM state machine on one shared memory port.
// Halts with a recorded cause on illegal/system instructions and misaligned accesses/targets.
module cpu_mc #(
  parameter logic [31:0] RESET_PC         = 32'h1eceb000,
  parameter int unsigned CNT_W            = 64,
  parameter bit          HALT_ON_MISALIGN = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  output logic [31:0]      mem_addr,
  output logic [3:0]       mem_rmask,
  output logic [3:0]       mem_wmask,
  input  logic [31:0]      mem_rdata,
  output logic [31:0]      mem_wdata,
  input  logic             mem_resp,
  output logic             halted,
  output logic [2:0]       halt_cause,
  output logic [CNT_W-1:0] instret
);

  typedef enum logic [2:0] {
    StReset, StFetch, StDecode, StExec, StMemLd, StMemSt, StHalt
  } state_e;

  localparam logic [6:0] OpLui = 7'h37, OpAuipc = 7'h17, OpJal = 7'h6f, OpJalr = 7'h67;
  localparam logic [6:0] OpBr = 7'h63, OpLd = 7'h03, OpSt = 7'h23, OpImm = 7'h13;
  localparam logic [6:0] OpReg = 7'h33, OpSys = 7'h73;

  state_e            state_q, state_d;
  logic [31:0]       pc_q, pc_d, ir_q, ir_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [2:0]        cause_q, cause_d;
  logic [31:0]       rf_q [32];
  logic              rd_we;
  logic [31:0]       rd_val;

  logic [6:0]  opcode;
  logic [4:0]  rd_idx, rs1_idx, rs2_idx;
  logic [2:0]  f3;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j, rs1_v, rs2_v;

  assign opcode  = ir_q[6:0];
  assign rd_idx  = ir_q[11:7];
  assign f3      = ir_q[14:12];
  assign rs1_idx = ir_q[19:15];
  assign rs2_idx = ir_q[24:20];
  assign imm_i   = {{20{ir_q[31]}}, ir_q[31:20]};
  assign imm_s   = {{20{ir_q[31]}}, ir_q[31:25], ir_q[11:7]};
  assign imm_b   = {{19{ir_q[31]}}, ir_q[31], ir_q[7], ir_q[30:25], ir_q[11:8], 1'b0};
  assign imm_u   = {ir_q[31:12], 12'b0};
  assign imm_j   = {{11{ir_q[31]}}, ir_q[31], ir_q[19:12], ir_q[20], ir_q[30:21], 1'b0};
  assign rs1_v   = (rs1_idx == 5'd0) ? 32'd0 : rf_q[rs1_idx];
  assign rs2_v   = (rs2_idx == 5'd0) ? 32'd0 : rf_q[rs2_idx];

  // ALU shared by OP and OP-IMM; funct7[5] selects SUB (OP only) and SRA/SRAI.
  logic [31:0] alu_b, alu_res;
  logic        alu_alt;
  always_comb begin
    alu_b   = (opcode == OpReg) ? rs2_v : imm_i;
    alu_alt = ir_q[30] && ((f3 == 3'b101) || (opcode == OpReg && f3 == 3'b000));
    case (f3)
      3'b000:  alu_res = alu_alt ? rs1_v - alu_b : rs1_v + alu_b;
      3'b001:  alu_res = rs1_v << alu_b[4:0];
      3'b010:  alu_res = {31'd0, $signed(rs1_v) < $signed(alu_b)};
      3'b011:  alu_res = {31'd0, rs1_v < alu_b};
      3'b100:  alu_res = rs1_v ^ alu_b;
      3'b101:  alu_res = alu_alt ? 32'($signed(rs1_v) >>> alu_b[4:0]) : rs1_v >> alu_b[4:0];
      3'b110:  alu_res = rs1_v | alu_b;
      default: alu_res = rs1_v & alu_b;
    endcase
  end

  logic        taken, is_xfer;
  logic [31:0] tgt;
  always_comb begin
    case (f3)
      3'b000:  taken = rs1_v == rs2_v;
      3'b001:  taken = rs1_v != rs2_v;
      3'b100:  taken = $signed(rs1_v) < $signed(rs2_v);
      3'b101:  taken = $signed(rs1_v) >= $signed(rs2_v);
      3'b110:  taken = rs1_v < rs2_v;
      3'b111:  taken = rs1_v >= rs2_v;
      default: taken = 1'b0;
    endcase
    is_xfer = (opcode == OpJal) || (opcode == OpJalr) || (opcode == OpBr && taken);
    case (opcode)
      OpJal:   tgt = pc_q + imm_j;
      OpJalr:  tgt = (rs1_v + imm_i) & 32'hffff_fffe;
      default: tgt = pc_q + imm_b;
    endcase
  end

  // Data address, lane masks and lane steering for loads and stores.
  logic [31:0] ea, ea_al, ld_sh, ld_val;
  logic [3:0]  lane_mask;
  logic        misal;
  always_comb begin
    ea    = rs1_v + ((opcode == OpSt) ? imm_s : imm_i);
    misal = (f3[1:0] == 2'd1 && ea[0]) || (f3[1:0] == 2'd2 && ea[1:0] != 2'd0);
    case (f3[1:0])
      2'd0:    begin ea_al = ea;                  lane_mask = 4'b0001 << ea[1:0]; end
      2'd1:    begin ea_al = {ea[31:1], 1'b0};    lane_mask = 4'b0011 << ea_al[1:0]; end
      default: begin ea_al = {ea[31:2], 2'b00};   lane_mask = 4'b1111; end
    endcase
    ld_sh = mem_rdata >> {ea_al[1:0], 3'b000};
    case (f3)
      3'b000:  ld_val = {{24{ld_sh[7]}}, ld_sh[7:0]};
      3'b001:  ld_val = {{16{ld_sh[15]}}, ld_sh[15:0]};
      3'b100:  ld_val = {24'd0, ld_sh[7:0]};
      3'b101:  ld_val = {16'd0, ld_sh[15:0]};
      default: ld_val = ld_sh;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    cnt_d     = cnt_q;
    cause_d   = cause_q;
    rd_we     = 1'b0;
    rd_val    = 32'd0;
    mem_addr  = 32'd0;
    mem_rmask = 4'd0;
    mem_wmask = 4'd0;
    mem_wdata = 32'd0;
    case (state_q)
      StReset: state_d = StFetch;
      StFetch: begin
        mem_addr  = pc_q;
        mem_rmask = 4'hf;
        if (mem_resp) begin
          ir_d    = mem_rdata;
          state_d = StDecode;
        end
      end
      StDecode: begin
        state_d = StHalt;
        cause_d = 3'd1;
        case (opcode)
          OpLui, OpAuipc, OpJal, OpImm, OpReg: state_d = StExec;
          OpJalr: if (f3 == 3'b000) state_d = StExec;
          OpBr:   if (f3[2:1] != 2'b01) state_d = StExec;
          OpLd:   if (f3 != 3'b011 && f3[2:1] != 2'b11) state_d = StMemLd;
          OpSt:   if (f3[2] == 1'b0 && f3[1:0] != 2'b11) state_d = StMemSt;
          OpSys: begin
            if (ir_q == 32'h0000_0073) cause_d = 3'd2;
            else if (ir_q == 32'h0010_0073) cause_d = 3'd3;
          end
          default: ;
        endcase
        if (state_d != StHalt) cause_d = cause_q;
      end
      StExec: begin
        if (is_xfer && tgt[1] && HALT_ON_MISALIGN) begin
          state_d = StHalt;
          cause_d = 3'd5;
        end else begin
          rd_we = (opcode != OpBr);
          case (opcode)
            OpLui:         rd_val = imm_u;
            OpAuipc:       rd_val = pc_q + imm_u;
            OpJal, OpJalr: rd_val = pc_q + 32'd4;
            default:       rd_val = alu_res;
          endcase
          pc_d    = is_xfer ? (tgt & 32'hffff_fffc) : pc_q + 32'd4;
          cnt_d   = cnt_q + CNT_W'(1);
          state_d = StFetch;
        end
      end
      StMemLd, StMemSt: begin
        if (misal && HALT_ON_MISALIGN) begin
          state_d = StHalt;
          cause_d = 3'd4;
        end else begin
          mem_addr = {ea_al[31:2], 2'b00};
          if (state_q == StMemLd) mem_rmask = lane_mask;
          else begin
            mem_wmask = lane_mask;
            mem_wdata = rs2_v << {ea_al[1:0], 3'b000};
          end
          if (mem_resp) begin
            rd_we   = (state_q == StMemLd);
            rd_val  = ld_val;
            pc_d    = pc_q + 32'd4;
            cnt_d   = cnt_q + CNT_W'(1);
            state_d = StFetch;
          end
        end
      end
      default: state_d = StHalt;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StReset;
      pc_q    <= RESET_PC;
      ir_q    <= 32'd0;
      cnt_q   <= '0;
      cause_q <= 3'd0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      cnt_q   <= cnt_d;
      cause_q <= cause_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && rd_we && rd_idx != 5'd0) rf_q[rd_idx] <= rd_val;
  end

  assign halted     = (state_q == StHalt);
  assign halt_cause = cause_q;
  assign instret    = cnt_q;

endmodule
